// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Definitions shared by the up counter and the countdown timer. It holds the
//   common state encoding, the default counter width, and a small helper that
//   reports whether a state belongs to an active count.
// ---------------------------------------------------------------------------
package counter_pkg;

   // This default width is shared with the free-running up counter.
   localparam int DefaultSize = 5;

   // IDLE waits for a start value. RUN decrements on each enabled cycle.
   // PAUSE holds the count while enable is low.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // A count is in progress in both RUN and PAUSE. The busy output uses this.
   function automatic logic isActive(input state_t s);
      return (s == RUN) || (s == PAUSE);
   endfunction

endpackage

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter used as a programmable interval or timeout source.
//   A start value is accepted over a valid/ready handshake while idle. The
//   count then decrements once per enabled cycle and done pulses when the
//   terminal decrement happens. The timer can optionally restart from the
//   stored value. It can be paused with enable low or aborted with cancel.
//
// Ports
//   clock        in   1     single clock, rising edge
//   reset        in   1     asynchronous, active-low (0 = in reset)
//   load_valid   in   1     start value offered
//   load_ready   out  1     timer accepts a value (idle and out of reset)
//   load_value   in   Size  start / reload value, sampled on handshake
//   enable       in   1     1 = decrement this cycle, 0 = pause
//   auto_reload  in   1     sampled on the terminal decrement
//   cancel       in   1     abort a running count without a done pulse
//   count        out  Size  current remaining count (registered)
//   busy         out  1     running or paused
//   paused       out  1     paused
//   done         out  1     one-cycle pulse on each terminal event
// ---------------------------------------------------------------------------
module countdown_timer
   import counter_pkg::*;
#(
   parameter int Size = DefaultSize
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [Size-1:0] load_value,
   input  logic            enable,
   input  logic            auto_reload,
   input  logic            cancel,
   output logic [Size-1:0] count,
   output logic            busy,
   output logic            paused,
   output logic            done
);

   state_t          r_state;
   logic [Size-1:0] r_count;
   logic [Size-1:0] r_reload;
   logic            r_done;

   // Main control block. State, count, reload value and the done flop all
   // live here.
   // - done is cleared by default every cycle, so it can only be high for
   //   the single cycle after a terminal event.
   // - In RUN and PAUSE, cancel is checked first. A cancel that lands on
   //   the terminal decrement therefore suppresses done.
   // - Loading zero counts as an immediate terminal event: done pulses and
   //   the timer stays idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (load_valid) begin
                  if (load_value != '0) begin
                     r_count  <= load_value;
                     r_reload <= load_value;
                     r_state  <= RUN;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            RUN, PAUSE: begin
               if (cancel) begin
                  r_count <= '0;
                  r_state <= IDLE;
               end else if (!enable) begin
                  r_state <= PAUSE;
               end else if (r_count > Size'(1)) begin
                  r_count <= r_count - Size'(1);
                  r_state <= RUN;
               end else if (r_count == Size'(1)) begin
                  r_done <= 1'b1;
                  if (auto_reload) begin
                     r_count <= r_reload;
                     r_state <= RUN;
                  end else begin
                     r_count <= '0;
                     r_state <= IDLE;
                  end
               end else begin
                  // An active count should never sit at zero. If it does,
                  // return to idle quietly rather than wrap.
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   // The status outputs are decoded straight from the registered state.
   // load_ready is also gated by reset, so no value can be offered as
   // accepted while the timer is held in reset.
   assign load_ready = reset && (r_state == IDLE);
   assign busy       = isActive(r_state);
   assign paused     = (r_state == PAUSE);
   assign count      = r_count;
   assign done       = r_done;

endmodule
